// File: rtl/placement_pkg.sv
// Shared placer/checker definitions: grid geometry, RAM widths, the checker
// state encoding and the (x,y) -> grid cell address mapping.
package placement_pkg;

  localparam int unsigned PL_N       = 9;   // grid side length
  localparam int unsigned PL_N_NODES = 9;   // node ids 0..PL_N_NODES-1
  localparam int unsigned PL_DATA_W  = 32;  // signed RAM word
  localparam int unsigned PL_POS_AW  = 7;   // pos_X / pos_Y address width
  localparam int unsigned PL_GRID_AW = 12;  // grid address width
  localparam int unsigned PL_CNT_W   = 16;  // result counter width

  // Marks an empty grid cell or an unplaced coordinate.
  localparam logic [PL_DATA_W-1:0] EMPTY = '1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_N_RD, ST_N_WAIT, ST_N_CHK,
    ST_G_RD, ST_G_WAIT, ST_G_CHK,
    ST_C_RD, ST_C_WAIT, ST_C_CHK,
    ST_B_RD, ST_B_WAIT, ST_B_CHK,
    ST_DONE
  } chk_state_e;

  // Row-major cell address; caller truncates to the grid address width.
  function automatic int unsigned cell_addr(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned n);
    return x * n + y;
  endfunction

endpackage

// File: rtl/placement_coord_cmp.sv
// Coordinate checks shared by the node pass and the back-reference pass.
//   x, y        : signed coordinates read from pos_X / pos_Y
//   row, col    : expected coordinates of the current grid cell
//   in_range_c  : both coordinates in 0..N-1 (signed compare)
//   match_c     : (x,y) equals (row,col)
module placement_coord_cmp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RC_W   = 12,
  parameter int unsigned N      = 9
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [RC_W-1:0]   row,
  input  logic [RC_W-1:0]   col,
  output logic              in_range_c,
  output logic              match_c
);

  // A set sign bit rules the coordinate out before the unsigned bound check.
  assign in_range_c = !x[DATA_W-1] && (x < DATA_W'(N)) &&
                      !y[DATA_W-1] && (y < DATA_W'(N));

  assign match_c = (x == DATA_W'(row)) && (y == DATA_W'(col));

endmodule

// File: rtl/placement_checker.sv
// Post-placement consistency checker. Pass 1 walks node ids and verifies each
// placed node's grid cell points back at it; pass 2 walks grid cells and
// verifies each occupant's position points back at the cell.
//   clk, reset            : clock, synchronous active-high reset
//   start / busy / done   : run request, run in progress, results-valid pulse
//   px_* / py_* / grid_*  : read-only ports to pos_X, pos_Y and grid RAMs
//   *_cnt, pass           : result counters and overall verdict
module placement_checker
  import placement_pkg::*;
#(
  parameter int unsigned N       = PL_N,
  parameter int unsigned N_NODES = PL_N_NODES,
  parameter int unsigned DATA_W  = PL_DATA_W,
  parameter int unsigned POS_AW  = PL_POS_AW,
  parameter int unsigned GRID_AW = PL_GRID_AW,
  parameter int unsigned CNT_W   = PL_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               px_rd,
  output logic [POS_AW-1:0]  px_addr,
  input  logic [DATA_W-1:0]  px_data,
  output logic               py_rd,
  output logic [POS_AW-1:0]  py_addr,
  input  logic [DATA_W-1:0]  py_data,
  output logic               grid_rd,
  output logic [GRID_AW-1:0] grid_addr,
  input  logic [DATA_W-1:0]  grid_data,
  output logic [CNT_W-1:0]   unplaced_cnt,
  output logic [CNT_W-1:0]   range_err_cnt,
  output logic [CNT_W-1:0]   mismatch_err_cnt,
  output logic [CNT_W-1:0]   occupied_cnt,
  output logic               pass
);

  chk_state_e state, nxt;

  logic [POS_AW-1:0]  node_idx, node_idx_d;
  logic [GRID_AW-1:0] cell_idx, cell_idx_d, row, row_d, col, col_d;
  logic               busy_d, done_d, px_rd_d, py_rd_d, grid_rd_d, pass_d;
  logic [POS_AW-1:0]  px_addr_d, py_addr_d;
  logic [GRID_AW-1:0] grid_addr_d;
  logic [CNT_W-1:0]   unplaced_d, range_d, mismatch_d, occupied_d;
  logic               adv_node, adv_cell;

  logic n_empty_c, in_range_c, match_c, c_empty_c, c_id_ok_c;
  logic last_node_c, last_cell_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  placement_coord_cmp #(.DATA_W(DATA_W), .RC_W(GRID_AW), .N(N)) u_cmp (
    .x          (px_data),
    .y          (py_data),
    .row        (row),
    .col        (col),
    .in_range_c (in_range_c),
    .match_c    (match_c)
  );

  assign n_empty_c   = (px_data == '1) && (py_data == '1);
  assign c_empty_c   = (grid_data == '1);
  assign c_id_ok_c   = !grid_data[DATA_W-1] && (grid_data < DATA_W'(N_NODES));
  assign last_node_c = (node_idx == POS_AW'(N_NODES - 1));
  assign last_cell_c = (cell_idx == GRID_AW'(N * N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = ST_N_RD;
      ST_N_RD:   nxt = ST_N_WAIT;
      ST_N_WAIT: nxt = ST_N_CHK;
      ST_N_CHK:
        if (n_empty_c || !in_range_c) nxt = last_node_c ? ST_C_RD : ST_N_RD;
        else                          nxt = ST_G_RD;
      ST_G_RD:   nxt = ST_G_WAIT;
      ST_G_WAIT: nxt = ST_G_CHK;
      ST_G_CHK:  nxt = last_node_c ? ST_C_RD : ST_N_RD;
      ST_C_RD:   nxt = ST_C_WAIT;
      ST_C_WAIT: nxt = ST_C_CHK;
      ST_C_CHK:
        if (!c_empty_c && c_id_ok_c) nxt = ST_B_RD;
        else                         nxt = last_cell_c ? ST_DONE : ST_C_RD;
      ST_B_RD:   nxt = ST_B_WAIT;
      ST_B_WAIT: nxt = ST_B_CHK;
      ST_B_CHK:  nxt = last_cell_c ? ST_DONE : ST_C_RD;
      ST_DONE:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    adv_node    = 1'b0;
    adv_cell    = 1'b0;
    busy_d      = (nxt != ST_IDLE);
    done_d      = 1'b0;
    px_rd_d     = 1'b0;
    py_rd_d     = 1'b0;
    grid_rd_d   = 1'b0;
    px_addr_d   = px_addr;
    py_addr_d   = py_addr;
    grid_addr_d = grid_addr;
    node_idx_d  = node_idx;
    cell_idx_d  = cell_idx;
    row_d       = row;
    col_d       = col;
    unplaced_d  = unplaced_cnt;
    range_d     = range_err_cnt;
    mismatch_d  = mismatch_err_cnt;
    occupied_d  = occupied_cnt;
    pass_d      = pass;

    case (state)
      ST_IDLE:
        if (start) begin
          unplaced_d = '0;
          range_d    = '0;
          mismatch_d = '0;
          occupied_d = '0;
          pass_d     = 1'b0;
          node_idx_d = '0;
          px_addr_d  = '0;
          py_addr_d  = '0;
          px_rd_d    = 1'b1;
          py_rd_d    = 1'b1;
        end
      ST_N_CHK:
        if (n_empty_c) begin
          unplaced_d = sat_inc(unplaced_cnt);
          adv_node   = 1'b1;
        end else if (!in_range_c) begin
          range_d  = sat_inc(range_err_cnt);
          adv_node = 1'b1;
        end else begin
          grid_rd_d   = 1'b1;
          grid_addr_d = GRID_AW'(cell_addr(32'(px_data), 32'(py_data), N));
        end
      ST_G_CHK: begin
        if (grid_data != DATA_W'(node_idx)) mismatch_d = sat_inc(mismatch_err_cnt);
        adv_node = 1'b1;
      end
      ST_C_CHK:
        if (c_empty_c) begin
          adv_cell = 1'b1;
        end else begin
          occupied_d = sat_inc(occupied_cnt);
          if (!c_id_ok_c) begin
            range_d  = sat_inc(range_err_cnt);
            adv_cell = 1'b1;
          end else begin
            px_rd_d   = 1'b1;
            py_rd_d   = 1'b1;
            px_addr_d = POS_AW'(grid_data);
            py_addr_d = POS_AW'(grid_data);
          end
        end
      ST_B_CHK: begin
        if (!match_c) mismatch_d = sat_inc(mismatch_err_cnt);
        adv_cell = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        pass_d = (range_err_cnt == '0) && (mismatch_err_cnt == '0) &&
                 (occupied_cnt == CNT_W'(N_NODES) - unplaced_cnt);
      end
      default: ;
    endcase

    // Step to the next node, or hand over to the cell pass after the last one.
    if (adv_node) begin
      if (last_node_c) begin
        cell_idx_d  = '0;
        row_d       = '0;
        col_d       = '0;
        grid_rd_d   = 1'b1;
        grid_addr_d = '0;
      end else begin
        node_idx_d = node_idx + POS_AW'(1);
        px_addr_d  = node_idx + POS_AW'(1);
        py_addr_d  = node_idx + POS_AW'(1);
        px_rd_d    = 1'b1;
        py_rd_d    = 1'b1;
      end
    end

    // Step to the next cell; row/col follow the cell index without a divider.
    if (adv_cell && !last_cell_c) begin
      cell_idx_d  = cell_idx + GRID_AW'(1);
      grid_addr_d = cell_idx + GRID_AW'(1);
      grid_rd_d   = 1'b1;
      if (col == GRID_AW'(N - 1)) begin
        col_d = '0;
        row_d = row + GRID_AW'(1);
      end else begin
        col_d = col + GRID_AW'(1);
      end
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      px_rd            <= 1'b0;
      py_rd            <= 1'b0;
      grid_rd          <= 1'b0;
      px_addr          <= '0;
      py_addr          <= '0;
      grid_addr        <= '0;
      node_idx         <= '0;
      cell_idx         <= '0;
      row              <= '0;
      col              <= '0;
      unplaced_cnt     <= '0;
      range_err_cnt    <= '0;
      mismatch_err_cnt <= '0;
      occupied_cnt     <= '0;
      pass             <= 1'b0;
    end else begin
      busy             <= busy_d;
      done             <= done_d;
      px_rd            <= px_rd_d;
      py_rd            <= py_rd_d;
      grid_rd          <= grid_rd_d;
      px_addr          <= px_addr_d;
      py_addr          <= py_addr_d;
      grid_addr        <= grid_addr_d;
      node_idx         <= node_idx_d;
      cell_idx         <= cell_idx_d;
      row              <= row_d;
      col              <= col_d;
      unplaced_cnt     <= unplaced_d;
      range_err_cnt    <= range_d;
      mismatch_err_cnt <= mismatch_d;
      occupied_cnt     <= occupied_d;
      pass             <= pass_d;
    end
  end

endmodule

// File: doc/placement_checker.md
Name: placement_checker

Overview:
- Read-side companion to the placer. After placement finishes, it reads back the pos_X, pos_Y and grid RAMs that the placer wrote.
- Checks that node→cell and cell→node mappings are mutually consistent and within the N×N grid. Reports error/occupancy counters and a pass flag.
- Sits beside the placer on the shared RAM read ports; the top level muxes the read ports to this block while the placer is idle.

Parameters:
- N, 9, grid side length (cells per row/column).
- N_NODES, 9, number of node ids (0..N_NODES-1).
- DATA_W, 32, RAM data width; signed two's complement; -1 marks empty/unplaced.
- POS_AW, 7, pos_X/pos_Y address width.
- GRID_AW, 12, grid address width; cell address = x*N+y.
- CNT_W, 16, width of result counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a check.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse when results are valid.
- px_rd  out  1  pos_X read enable.
- px_addr  out  POS_AW  pos_X address.
- px_data  in  DATA_W  pos_X read data.
- py_rd  out  1  pos_Y read enable.
- py_addr  out  POS_AW  pos_Y address.
- py_data  in  DATA_W  pos_Y read data.
- grid_rd  out  1  grid read enable.
- grid_addr  out  GRID_AW  grid address.
- grid_data  in  DATA_W  grid read data.
- unplaced_cnt  out  CNT_W  nodes with x=-1 and y=-1.
- range_err_cnt  out  CNT_W  out-of-range coordinates or node ids.
- mismatch_err_cnt  out  CNT_W  broken back-references.
- occupied_cnt  out  CNT_W  grid cells not equal to -1.
- pass  out  1  all error counters zero and occupied_cnt == N_NODES - unplaced_cnt.

Behaviour:
- Reset (synchronous):
  - State IDLE.
  - All outputs 0: rd enables, addresses, busy, done, counters, pass.
- RAM timing: read enables and addresses are registered outputs. Read data is sampled in the cycle after the cycle in which the enable was high (one WAIT state).
- Read strobes: each rd is high for exactly one cycle per access. There are no writes.
- IDLE:
  - start=1 → clear all counters and pass, set busy=1, node index i=0, go N_RD.
  - start while busy is ignored.
- Pass 1, per node (for i in 0..N_NODES-1):
  - N_RD: px_rd=py_rd=1, addr=i. → N_WAIT.
  - N_WAIT → N_CHK.
  - N_CHK:
    - Both data = -1 → unplaced++, next node.
    - Else if either coordinate <0 or ≥N (signed compare; half-placed counts here) → range_err++, next node.
    - Else latch x,y → G_RD.
  - G_RD: grid_rd=1, grid_addr=x*N+y (product truncated to GRID_AW). → G_WAIT → G_CHK.
  - G_CHK: grid_data≠i → mismatch++. Next node.
- Pass-1 cost: 3 cycles per unplaced or range-error node, 6 cycles per placed node.
- Transition after i = N_NODES-1: set c=0, go C_RD.
- Pass 2, per cell (for c in 0..N*N-1):
  - C_RD: grid_rd=1, grid_addr=c. → C_WAIT → C_CHK.
  - C_CHK:
    - -1 → next cell.
    - Else occupied++.
    - If value <0 or ≥N_NODES → range_err++, next cell.
    - Else B_RD with px/py addr=value → B_WAIT → B_CHK.
  - B_CHK: (px_data,py_data) ≠ (c/N, c%N) → mismatch++. Next cell. Row/col are tracked by counters, not by a divider.
- Pass-2 cost: 3 cycles per empty cell, 6 per occupied cell.
- After the last cell: DONE state.
  - pass computed, done=1 for one cycle, busy=0 → IDLE.
- Result hold: counters and pass hold until the next accepted start.
- Saturation: counters saturate at 2^CNT_W-1.
- Duplicate node in two cells: one cell passes the back-check, the other gives a mismatch, and occupied exceeds the placed count, so pass=0.
- Reset mid-run: immediate return to IDLE with outputs cleared. No done pulse.
- Latency from start cycle to done pulse: 1 + pass1 cycles + pass2 cycles + 1.

Decomposition:
- Shared package placement_pkg:
  - EMPTY = -1, DATA_W.
  - State encoding enum for this FSM.
  - Function cell_addr(x,y,N).
  - Placer parameters shared with the placer (N, address widths).
- One natural sub-module: placement_coord_cmp. Combinational in-range check and (x,y)-vs-(row,col) compare, reused by N_CHK and B_CHK.

Test Plan:
- Valid full placement: 9 nodes placed, one per cell, consistent → occupied=9, all errors 0, unplaced=0, pass=1, done at cycle 1+54+(72·3+9·6)+1=326 after start.
- Node 4 pos=(-1,-1) and grid holds no 4 → unplaced=1, occupied=8, pass=1.
- Node 2 pos=(3,9) → range_err=1, pass=0; grid cell holding 2 also mismatches → mismatch=1.
- grid[10]=5 but pos(5)=(2,2) → mismatch_err_cnt=2 (pass 1 and pass 2), pass=0.
- Node 7 written in grid cells 0 and 80, pos(7)=(0,0) → occupied=10, mismatch=1, pass=0.
- Reset asserted 20 cycles after start → next cycle busy=0, counters 0, no done. A fresh start then completes normally; a start during busy is ignored.
